// File: rtl/noc_filereg_pkg.sv
// rtl/noc_filereg_pkg.sv - filereg request/response widths, field offsets and packed types
package noc_filereg_pkg;

  localparam int FILEREG_REQ_W = 39;
  localparam int FILEREG_RSP_W = 43;

  localparam int REQ_OP_BIT   = 38;
  localparam int REQ_ADDR_LSB = 32;
  localparam int REQ_DATA_LSB = 0;

  localparam int RSP_ERR_BIT  = 42;
  localparam int RSP_ADDR_LSB = 36;
  localparam int RSP_SEQ_LSB  = 32;
  localparam int RSP_DATA_LSB = 0;

  typedef enum logic {
    FILEREG_WRITE = 1'b0,
    FILEREG_READ  = 1'b1
  } filereg_op_e;

  typedef struct packed {
    filereg_op_e op;
    logic [5:0]  addr;
    logic [31:0] data;
  } filereg_req_t;

  typedef struct packed {
    logic        err;
    logic [5:0]  addr;
    logic [3:0]  seq;
    logic [31:0] data;
  } filereg_rsp_t;

endpackage

// File: rtl/noc_router_filereg_responder.sv
// rtl/noc_router_filereg_responder.sv - router-side filereg endpoint: local config register file
// Writes land in one cycle; reads are answered with a registered, sequence-tagged response.
module noc_router_filereg_responder
  import noc_filereg_pkg::*;
#(
  parameter int                         NumRegisters = 16,
  parameter logic [NumRegisters-1:0]    ReadOnlyMask = 16'h8000,
  parameter logic [NumRegisters*32-1:0] ResetValues  = '0
) (
  input  logic                         clk_network_i,
  input  logic                         rst_network_ni,
  input  logic                         s_filereg_valid_i,
  output logic                         s_filereg_ready_o,
  input  logic [FILEREG_REQ_W-1:0]     s_filereg_data_i,
  output logic                         m_filereg_valid_o,
  input  logic                         m_filereg_ready_i,
  output logic [FILEREG_RSP_W-1:0]     m_filereg_data_o,
  input  logic [NumRegisters*32-1:0]   status_i,
  output logic [NumRegisters*32-1:0]   cfg_regs_o,
  output logic [NumRegisters-1:0]      cfg_wr_pulse_o,
  output logic [7:0]                   wr_err_count_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic                      s_ready_q, s_ready_d;
  logic                      m_valid_q, m_valid_d;
  filereg_rsp_t              m_data_q, m_data_d;
  logic [3:0]                seq_q, seq_d;
  logic [7:0]                wr_err_count_q, wr_err_count_d;
  logic [NumRegisters-1:0]   cfg_wr_pulse_q, cfg_wr_pulse_d;
  logic [31:0]               regs_q [NumRegisters];
  logic [31:0]               regs_d [NumRegisters];

  filereg_req_t req;
  logic         accept;
  logic         addr_hit;
  logic         addr_ro;
  logic         wr_en;
  logic [31:0]  rd_word;

  always_comb begin
    req            = filereg_req_t'(s_filereg_data_i);
    accept         = s_filereg_valid_i && s_ready_q;
    state_d        = state_q;
    s_ready_d      = s_ready_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    seq_d          = seq_q;
    wr_err_count_d = wr_err_count_q;
    cfg_wr_pulse_d = '0;
    regs_d         = regs_q;
    addr_hit       = 1'b0;
    addr_ro        = 1'b0;
    wr_en          = 1'b0;
    rd_word        = '0;

    // Address decode; read-only slots return live status instead of storage.
    for (int i = 0; i < NumRegisters; i++) begin
      if (req.addr == 6'(i)) begin
        addr_hit = 1'b1;
        addr_ro  = ReadOnlyMask[i];
        rd_word  = ReadOnlyMask[i] ? status_i[i*32 +: 32] : regs_q[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req.op == FILEREG_READ) begin
            m_data_d.err  = !addr_hit;
            m_data_d.addr = req.addr;
            m_data_d.seq  = seq_q;
            m_data_d.data = addr_hit ? rd_word : 32'h0;
            m_valid_d     = 1'b1;
            s_ready_d     = 1'b0;
            state_d       = ST_RESP;
          end else if (addr_hit && !addr_ro) begin
            wr_en = 1'b1;
          end else if (wr_err_count_q != 8'hFF) begin
            wr_err_count_d = wr_err_count_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        if (m_filereg_ready_i) begin
          m_valid_d = 1'b0;
          seq_d     = seq_q + 4'd1;
          s_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
      end
    endcase

    for (int i = 0; i < NumRegisters; i++) begin
      if (wr_en && (req.addr == 6'(i))) begin
        regs_d[i]         = req.data;
        cfg_wr_pulse_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) begin
      state_q        <= ST_IDLE;
      s_ready_q      <= 1'b1;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      seq_q          <= '0;
      wr_err_count_q <= '0;
      cfg_wr_pulse_q <= '0;
      for (int i = 0; i < NumRegisters; i++) begin
        regs_q[i] <= ResetValues[i*32 +: 32];
      end
    end else begin
      state_q        <= state_d;
      s_ready_q      <= s_ready_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      seq_q          <= seq_d;
      wr_err_count_q <= wr_err_count_d;
      cfg_wr_pulse_q <= cfg_wr_pulse_d;
      regs_q         <= regs_d;
    end
  end

  always_comb begin
    cfg_regs_o = '0;
    for (int i = 0; i < NumRegisters; i++) begin
      cfg_regs_o[i*32 +: 32] = ReadOnlyMask[i] ? 32'h0 : regs_q[i];
    end
  end

  assign s_filereg_ready_o = s_ready_q;
  assign m_filereg_valid_o = m_valid_q;
  assign m_filereg_data_o  = m_data_q;
  assign cfg_wr_pulse_o    = cfg_wr_pulse_q;
  assign wr_err_count_o    = wr_err_count_q;

endmodule
